// File: rtl/sort_stream_loader.sv
// Streams N words from a source buffer into an external sorter, waits for the sorted result,
// then drains it into a destination buffer. A bounded wait guards against a stuck sorter.
module sort_stream_loader #(
    parameter int unsigned LOG_INPUT_NUM = 7,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDR_WIDTH    = 12,
    parameter int unsigned TIMEOUT       = 65535
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] src_base,
    input  logic [ADDR_WIDTH-1:0] dst_base,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  s_rst,
    output logic [DATA_WIDTH-1:0] s_din,
    output logic                  s_load,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_dout,
    output logic                  s_unload
);

    localparam int unsigned N      = 2 ** LOG_INPUT_NUM;
    localparam int unsigned FillW  = LOG_INPUT_NUM + 2;
    localparam int unsigned DrainW = LOG_INPUT_NUM + 1;
    localparam int unsigned TimerW = $clog2(TIMEOUT + 1);

    // FILL keeps counting past the reads so the two-cycle load pipeline can empty.
    localparam logic [FillW-1:0]  RdLimit   = FillW'(N);
    localparam logic [FillW-1:0]  FillLast  = FillW'(N + 1);
    localparam logic [DrainW-1:0] DrainLast = DrainW'(N - 1);
    localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StClr,
        StFill,
        StWait,
        StDrain,
        StFin
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] src_q, src_d;
    logic [ADDR_WIDTH-1:0] dst_q, dst_d;
    logic [FillW-1:0]      fill_q, fill_d;
    logic [DrainW-1:0]     drain_q, drain_d;
    logic [TimerW-1:0]     timer_q, timer_d;
    logic                  error_q, error_d;
    logic                  s_rst_q, s_rst_d;
    logic                  rd_vld_q;
    logic                  s_load_q;
    logic [DATA_WIDTH-1:0] s_din_q;

    logic                  rd_fire;
    logic                  wr_fire;
    logic                  timeout_fire;

    always_comb begin
        state_d      = state_q;
        src_d        = src_q;
        dst_d        = dst_q;
        fill_d       = fill_q;
        drain_d      = drain_q;
        timer_d      = timer_q;
        error_d      = error_q;
        rd_fire      = 1'b0;
        wr_fire      = 1'b0;
        timeout_fire = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    src_d   = src_base;
                    dst_d   = dst_base;
                    error_d = 1'b0;
                    state_d = StClr;
                end
            end
            StClr: begin
                fill_d  = '0;
                state_d = StFill;
            end
            StFill: begin
                rd_fire = (fill_q < RdLimit);
                if (fill_q == FillLast) begin
                    timer_d = '0;
                    state_d = StWait;
                end else begin
                    fill_d = fill_q + 1'b1;
                end
            end
            StWait: begin
                if (s_valid) begin
                    drain_d = '0;
                    state_d = StDrain;
                end else if (timer_q == TimerLast) begin
                    error_d      = 1'b1;
                    timeout_fire = 1'b1;
                    state_d      = StIdle;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StDrain: begin
                if (s_valid) begin
                    wr_fire = 1'b1;
                    drain_d = drain_q + 1'b1;
                    if (drain_q == DrainLast) begin
                        state_d = StFin;
                    end
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Sorter reset is registered so it can be held high through the async reset.
        s_rst_d = (state_d == StClr) || timeout_fire;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            src_q   <= '0;
            dst_q   <= '0;
            fill_q  <= '0;
            drain_q <= '0;
            timer_q <= '0;
            error_q <= 1'b0;
            s_rst_q <= 1'b1;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            fill_q  <= fill_d;
            drain_q <= drain_d;
            timer_q <= timer_d;
            error_q <= error_d;
            s_rst_q <= s_rst_d;
        end
    end

    // Read data lands one cycle after rd_en; it is registered before being offered to the sorter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_vld_q <= 1'b0;
            s_load_q <= 1'b0;
            s_din_q  <= '0;
        end else begin
            rd_vld_q <= rd_fire;
            s_load_q <= rd_vld_q;
            if (rd_vld_q) begin
                s_din_q <= rd_data;
            end
        end
    end

    assign busy     = (state_q != StIdle);
    assign done     = (state_q == StFin);
    assign error    = error_q;
    assign rd_en    = rd_fire;
    assign rd_addr  = rd_fire ? (src_q + ADDR_WIDTH'(fill_q)) : '0;
    assign wr_en    = wr_fire;
    assign wr_addr  = wr_fire ? (dst_q + ADDR_WIDTH'(drain_q)) : '0;
    assign wr_data  = wr_fire ? s_dout : '0;
    assign s_unload = wr_fire;
    assign s_rst    = s_rst_q;
    assign s_din    = s_din_q;
    assign s_load   = s_load_q;

endmodule

// File: tb/tb_sort_stream_loader.sv
// Bench for sort_stream_loader with N=4: source memory, ascending sorter model and a
// scoreboard of expected reads, sorter loads and destination writes.
module tb_sort_stream_loader;

    localparam int LOG_N = 2;
    localparam int N     = 4;
    localparam int DW    = 32;
    localparam int AW    = 12;
    localparam int TO    = 20;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] src_base = '0;
    logic [AW-1:0] dst_base = '0;
    logic          busy, done, error;
    logic          rd_en, wr_en, s_rst, s_load, s_valid, s_unload;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [DW-1:0] rd_data = '0;
    logic [DW-1:0] wr_data, s_din, s_dout;

    always #5 clk = ~clk;

    sort_stream_loader #(
        .LOG_INPUT_NUM(LOG_N),
        .DATA_WIDTH   (DW),
        .ADDR_WIDTH   (AW),
        .TIMEOUT      (TO)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .src_base(src_base),
        .dst_base(dst_base),
        .busy    (busy),
        .done    (done),
        .error   (error),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .s_rst   (s_rst),
        .s_din   (s_din),
        .s_load  (s_load),
        .s_valid (s_valid),
        .s_dout  (s_dout),
        .s_unload(s_unload)
    );

    // Source buffer: data valid one cycle after rd_en.
    logic [DW-1:0] src_mem [1 << AW];
    always @(posedge clk) if (rd_en) rd_data <= src_mem[rd_addr];

    // Sorter model: collects N loads, then presents them ascending.
    logic [N-1:0][DW-1:0] in_vec = '0;
    logic [N-1:0][DW-1:0] out_vec = '0;
    int  in_cnt = 0;
    int  out_idx = 0;
    bit  sorted = 1'b0;
    bit  stall = 1'b0;
    bit  suppress = 1'b0;

    function automatic logic [N-1:0][DW-1:0] sort_asc(input logic [N-1:0][DW-1:0] v,
                                                       input logic [DW-1:0] last);
        logic [DW-1:0] t;
        v[N-1] = last;
        for (int a = 0; a < N - 1; a++)
            for (int b = 0; b < N - 1 - a; b++)
                if (v[b] > v[b+1]) begin
                    t = v[b]; v[b] = v[b+1]; v[b+1] = t;
                end
        return v;
    endfunction

    always @(posedge clk) begin
        if (s_rst) begin
            in_cnt  <= 0;
            out_idx <= 0;
            sorted  <= 1'b0;
        end else begin
            if (s_load && in_cnt < N) begin
                in_vec[in_cnt[1:0]] <= s_din;
                in_cnt <= in_cnt + 1;
                if (in_cnt == N - 1) begin
                    out_vec <= sort_asc(in_vec, s_din);
                    sorted  <= 1'b1;
                end
            end
            if (s_unload && s_valid) out_idx <= out_idx + 1;
        end
    end

    assign s_valid = sorted && (out_idx < N) && !stall && !suppress;
    assign s_dout  = (sorted && out_idx < N) ? out_vec[out_idx[1:0]] : '0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard and counters.
    logic [AW-1:0]    exp_rd[$];
    logic [DW-1:0]    exp_ld[$];
    logic [AW+DW-1:0] exp_wr[$];
    int total = 0, bad = 0;
    int done_cnt = 0, wr_cnt = 0, srst_cnt = 0, wr_at_done = 0;
    int first_wr_cyc = -1, start_cyc = 0;

    logic [AW-1:0]    m_rd;
    logic [DW-1:0]    m_ld;
    logic [AW+DW-1:0] m_wr;

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                if (rd_en === 1'b1) begin
                    total++;
                    if (exp_rd.size() == 0) begin
                        bad++; $display("FAIL rd_extra: got addr %h, none expected", rd_addr);
                    end else begin
                        m_rd = exp_rd.pop_front();
                        if (rd_addr !== m_rd) begin
                            bad++; $display("FAIL rd_addr: got %h want %h", rd_addr, m_rd);
                        end
                    end
                end
                if (s_load === 1'b1) begin
                    total++;
                    if (exp_ld.size() == 0) begin
                        bad++; $display("FAIL load_extra: got %0d, none expected", s_din);
                    end else begin
                        m_ld = exp_ld.pop_front();
                        if (s_din !== m_ld) begin
                            bad++; $display("FAIL s_din: got %0d want %0d", s_din, m_ld);
                        end
                    end
                end
                if (wr_en === 1'b1) begin
                    total++;
                    wr_cnt++;
                    if (first_wr_cyc < 0) first_wr_cyc = cyc;
                    if (exp_wr.size() == 0) begin
                        bad++; $display("FAIL wr_extra: got %h/%0d", wr_addr, wr_data);
                    end else begin
                        m_wr = exp_wr.pop_front();
                        if ({wr_addr, wr_data} !== m_wr) begin
                            bad++;
                            $display("FAIL write: got %h/%0d want %h/%0d", wr_addr, wr_data,
                                     m_wr[AW+DW-1:DW], m_wr[DW-1:0]);
                        end
                    end
                end
                if (wr_en === 1'b1 || s_unload === 1'b1) begin
                    total++;
                    if (s_unload !== wr_en) begin
                        bad++; $display("FAIL unload_pair: s_unload %b wr_en %b", s_unload, wr_en);
                    end
                end
                if (stall) begin
                    total++;
                    if (wr_en !== 1'b0) begin
                        bad++; $display("FAIL stall_write: wr_en %b want 0", wr_en);
                    end
                end
                if (done === 1'b1) begin
                    done_cnt++;
                    wr_at_done = wr_cnt;
                end
                if (s_rst === 1'b1) srst_cnt++;
            end
        end
    end

    task automatic push_xfer(input logic [AW-1:0] src, input logic [AW-1:0] dst,
                             input logic [DW-1:0] a, input logic [DW-1:0] b,
                             input logic [DW-1:0] c, input logic [DW-1:0] d,
                             input logic [DW-1:0] s0, input logic [DW-1:0] s1,
                             input logic [DW-1:0] s2, input logic [DW-1:0] s3,
                             input bit writes);
        logic [DW-1:0] v[N];
        logic [DW-1:0] s[N];
        logic [AW-1:0] ad;
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
        for (int k = 0; k < N; k++) begin
            ad = src + AW'(k);
            src_mem[ad] = v[k];
            exp_rd.push_back(ad);
            exp_ld.push_back(v[k]);
            if (writes) begin
                ad = dst + AW'(k);
                exp_wr.push_back({ad, s[k]});
            end
        end
        done_cnt = 0; wr_cnt = 0; srst_cnt = 0; wr_at_done = 0; first_wr_cyc = -1;
    endtask

    task automatic kick(input logic [AW-1:0] src, input logic [AW-1:0] dst);
        @(negedge clk);
        src_base  = src;
        dst_base  = dst;
        start     = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset;
        @(negedge clk);
        total++;
        if ({busy, done, error, rd_en, wr_en, s_load, s_unload} !== 7'b0) begin
            bad++; $display("FAIL reset_strobes: got %b want 0",
                            {busy, done, error, rd_en, wr_en, s_load, s_unload});
        end
        total++;
        if (s_rst !== 1'b1) begin bad++; $display("FAIL reset_s_rst: got %b want 1", s_rst); end
        total++;
        if ({rd_addr, wr_addr} !== '0) begin
            bad++; $display("FAIL reset_addr: got %h/%h want 0", rd_addr, wr_addr);
        end
        total++;
        if ({wr_data, s_din} !== '0) begin
            bad++; $display("FAIL reset_data: got %h/%h want 0", wr_data, s_din);
        end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({s_rst, busy} !== 2'b00) begin
            bad++; $display("FAIL post_reset: s_rst/busy %b want 00", {s_rst, busy});
        end
    endtask

    task automatic test_basic_sort;
        bit ok;
        push_xfer(12'h010, 12'h020, 32'd9, 32'd3, 32'd7, 32'd1,
                  32'd1, 32'd3, 32'd7, 32'd9, 1'b1);
        kick(12'h010, 12'h020);
        wait_done(60, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL basic_done_seen: got 0 want 1"); end
        total++;
        if (done_cnt !== 1) begin bad++; $display("FAIL basic_done_cnt: got %0d want 1", done_cnt); end
        total++;
        if (wr_at_done !== 4) begin bad++; $display("FAIL basic_wr_at_done: got %0d want 4", wr_at_done); end
        total++;
        if (error !== 1'b0) begin bad++; $display("FAIL basic_error: got %b want 0", error); end
        total++;
        if (first_wr_cyc - start_cyc !== 9) begin
            bad++; $display("FAIL basic_latency: got %0d want 9", first_wr_cyc - start_cyc);
        end
        total++;
        if (exp_rd.size() + exp_ld.size() + exp_wr.size() !== 0) begin
            bad++; $display("FAIL basic_leftover: got %0d want 0",
                            exp_rd.size() + exp_ld.size() + exp_wr.size());
        end
    endtask

    task automatic test_addr_wrap;
        bit ok;
        push_xfer(12'hFFE, 12'h300, 32'd5, 32'd2, 32'd8, 32'd4,
                  32'd2, 32'd4, 32'd5, 32'd8, 1'b1);
        kick(12'hFFE, 12'h300);
        wait_done(60, ok);
        total++;
        if (!ok || done_cnt !== 1) begin
            bad++; $display("FAIL wrap_done: got %0d want 1", done_cnt);
        end
        total++;
        if (exp_rd.size() + exp_wr.size() !== 0) begin
            bad++; $display("FAIL wrap_leftover: got %0d want 0", exp_rd.size() + exp_wr.size());
        end
    endtask

    task automatic test_drain_stall;
        bit ok;
        int n = 0;
        push_xfer(12'h040, 12'h050, 32'd100, 32'd50, 32'd75, 32'd25,
                  32'd25, 32'd50, 32'd75, 32'd100, 1'b1);
        kick(12'h040, 12'h050);
        for (int i = 0; i < 40 && n < 2; i++) begin
            @(negedge clk);
            if (wr_en === 1'b1) n++;
        end
        total++;
        if (n !== 2) begin bad++; $display("FAIL stall_pre_writes: got %0d want 2", n); end
        @(posedge clk);
        #1 stall = 1'b1;
        repeat (3) @(posedge clk);
        #1 stall = 1'b0;
        wait_done(40, ok);
        total++;
        if (!ok || done_cnt !== 1) begin
            bad++; $display("FAIL stall_done: got %0d want 1", done_cnt);
        end
        total++;
        if (wr_cnt !== 4 || wr_at_done !== 4) begin
            bad++; $display("FAIL stall_writes: got %0d/%0d want 4/4", wr_cnt, wr_at_done);
        end
        total++;
        if (exp_wr.size() !== 0) begin
            bad++; $display("FAIL stall_leftover: got %0d want 0", exp_wr.size());
        end
    endtask

    task automatic test_timeout;
        bit ok;
        bit fell = 1'b0;
        int end_cyc = 0;
        suppress = 1'b1;
        push_xfer(12'h060, 12'h070, 32'd4, 32'd3, 32'd2, 32'd1,
                  32'd1, 32'd2, 32'd3, 32'd4, 1'b0);
        kick(12'h060, 12'h070);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy !== 1'b1) begin fell = 1'b1; end_cyc = cyc; break; end
        end
        total++;
        if (!fell || end_cyc - start_cyc !== 28) begin
            bad++; $display("FAIL timeout_cycles: got %0d want 28", end_cyc - start_cyc);
        end
        total++;
        if (error !== 1'b1) begin bad++; $display("FAIL timeout_error: got %b want 1", error); end
        total++;
        if (s_rst !== 1'b1) begin bad++; $display("FAIL timeout_s_rst: got %b want 1", s_rst); end
        @(negedge clk);
        total++;
        if (s_rst !== 1'b0 || srst_cnt !== 2) begin
            bad++; $display("FAIL timeout_s_rst_pulse: got %b cnt %0d want 0 cnt 2", s_rst, srst_cnt);
        end
        total++;
        if (done_cnt !== 0) begin bad++; $display("FAIL timeout_done: got %0d want 0", done_cnt); end
        repeat (3) @(negedge clk);
        total++;
        if (error !== 1'b1) begin bad++; $display("FAIL timeout_sticky: got %b want 1", error); end
        suppress = 1'b0;
        push_xfer(12'h060, 12'h070, 32'd4, 32'd3, 32'd2, 32'd1,
                  32'd1, 32'd2, 32'd3, 32'd4, 1'b1);
        kick(12'h060, 12'h070);
        total++;
        if (error !== 1'b0) begin bad++; $display("FAIL timeout_clear: got %b want 0", error); end
        wait_done(60, ok);
        total++;
        if (!ok || done_cnt !== 1 || exp_wr.size() !== 0) begin
            bad++; $display("FAIL timeout_retry: done %0d left %0d want 1/0", done_cnt, exp_wr.size());
        end
    endtask

    task automatic test_busy_reject;
        bit ok;
        push_xfer(12'h080, 12'h090, 32'd11, 32'd44, 32'd22, 32'd33,
                  32'd11, 32'd22, 32'd33, 32'd44, 1'b1);
        @(negedge clk);
        src_base = 12'h080; dst_base = 12'h090; start = 1'b1; start_cyc = cyc;
        @(negedge clk);
        src_base = 12'hA00; dst_base = 12'hB00;
        for (int i = 0; i < 60; i++) begin
            if (done === 1'b1) break;
            @(negedge clk);
        end
        // start stays high through the done cycle, released just after it
        @(posedge clk);
        #1 start = 1'b0;
        repeat (6) @(negedge clk);
        ok = (done_cnt == 1);
        total++;
        if (!ok) begin bad++; $display("FAIL reject_done_cnt: got %0d want 1", done_cnt); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reject_busy: got %b want 0", busy); end
        total++;
        if (exp_rd.size() + exp_wr.size() !== 0) begin
            bad++; $display("FAIL reject_leftover: got %0d want 0", exp_rd.size() + exp_wr.size());
        end
    endtask

    task automatic test_mid_reset;
        bit ok;
        int n = 0;
        push_xfer(12'h030, 12'h038, 32'd6, 32'd8, 32'd5, 32'd7,
                  32'd5, 32'd6, 32'd7, 32'd8, 1'b1);
        kick(12'h030, 12'h038);
        for (int i = 0; i < 20 && n < 2; i++) begin
            if (n < 2) @(negedge clk);
            if (rd_en === 1'b1) n++;
        end
        #2 rst = 1'b0;
        #1;
        total++;
        if ({rd_en, wr_en, s_load, s_unload, busy, done} !== 6'b0 || s_rst !== 1'b1) begin
            bad++; $display("FAIL midrst_strobes: got %b s_rst %b want 0 s_rst 1",
                            {rd_en, wr_en, s_load, s_unload, busy, done}, s_rst);
        end
        exp_rd.delete(); exp_ld.delete(); exp_wr.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if ({rd_en, wr_en, s_load, s_unload, busy, s_rst} !== 6'b0) begin
                bad++; $display("FAIL midrst_residual: got %b want 0",
                                {rd_en, wr_en, s_load, s_unload, busy, s_rst});
            end
        end
        push_xfer(12'h030, 12'h038, 32'd6, 32'd8, 32'd5, 32'd7,
                  32'd5, 32'd6, 32'd7, 32'd8, 1'b1);
        kick(12'h030, 12'h038);
        wait_done(60, ok);
        total++;
        if (!ok || done_cnt !== 1) begin bad++; $display("FAIL midrst_done: got %0d want 1", done_cnt); end
        total++;
        if (first_wr_cyc - start_cyc !== 9) begin
            bad++; $display("FAIL midrst_latency: got %0d want 9", first_wr_cyc - start_cyc);
        end
        total++;
        if (exp_rd.size() + exp_ld.size() + exp_wr.size() !== 0) begin
            bad++; $display("FAIL midrst_leftover: got %0d want 0",
                            exp_rd.size() + exp_ld.size() + exp_wr.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic_sort();
        test_addr_wrap();
        test_drain_stall();
        test_timeout();
        test_busy_reject();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sort_stream_loader.md
SORT_STREAM_LOADER -- requirements
Module: sort_stream_loader

Interface
REQ-001 SHALL have parameter LOG_INPUT_NUM, default 7: sort length N = 2**LOG_INPUT_NUM words.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: width of the word datapath.
REQ-003 SHALL have parameter ADDR_WIDTH, default 12: width of the word address on the buffer ports.
REQ-004 SHALL have parameter TIMEOUT, default 65535: maximum cycles spent in WAIT.
REQ-005 SHALL have ports, in this order:
  clk  in  1  sole clock; all state changes on its rising edge.
  rst  in  1  asynchronous, active-low reset.
  start  in  1  command pulse; accepted only in IDLE.
  src_base  in  ADDR_WIDTH  source word address, captured at start.
  dst_base  in  ADDR_WIDTH  destination word address, captured at start.
  busy  out  1  high in every state except IDLE.
  done  out  1  one-cycle pulse on successful completion.
  error  out  1  sticky timeout flag; cleared by the next accepted start.
  rd_en  out  1  source buffer read strobe.
  rd_addr  out  ADDR_WIDTH  source word address.
  rd_data  in  DATA_WIDTH  source data, valid exactly 1 cycle after rd_en.
  wr_en  out  1  destination buffer write strobe.
  wr_addr  out  ADDR_WIDTH  destination word address.
  wr_data  out  DATA_WIDTH  destination data.
  s_rst  out  1  sorter reset, active-high.
  s_din  out  DATA_WIDTH  word presented to the sorter.
  s_load  out  1  sorter input strobe; one word per high cycle.
  s_valid  in  1  sorter result-ready flag.
  s_dout  in  DATA_WIDTH  current sorter output word.
  s_unload  out  1  sorter output-advance strobe; one word per high cycle.

Function
REQ-006 SHALL implement a state machine with states IDLE, CLR, FILL, WAIT, DRAIN, FIN.
REQ-007 SHALL, in IDLE on start=1, capture src_base and dst_base, clear error, and enter CLR.
REQ-008 SHALL, in CLR, drive s_rst=1 for exactly 1 cycle, then enter FILL.
REQ-009 SHALL, in FILL, assert rd_en for N consecutive cycles with rd_addr = src_base+i, i = 0..N-1, where address arithmetic wraps modulo 2**ADDR_WIDTH.
REQ-010 SHALL register rd_data into s_din and assert s_load 1 cycle after each rd_data becomes valid (2 cycles after the corresponding rd_en), giving N consecutive s_load cycles in source order.
REQ-011 SHALL leave FILL for WAIT in the cycle after the last s_load.
REQ-012 SHALL, in WAIT, enter DRAIN on the first cycle s_valid=1 is sampled; the cycle counter starts at 0 on WAIT entry.
REQ-013 SHALL, if the WAIT cycle counter reaches TIMEOUT without s_valid, set error=1, assert s_rst for 1 cycle, and return to IDLE without pulsing done.
REQ-014 SHALL, in DRAIN on each cycle with s_valid=1, drive wr_en=1, wr_data=s_dout, wr_addr=dst_base+j and s_unload=1, then increment j; j starts at 0 and wraps modulo 2**ADDR_WIDTH.
REQ-015 SHALL, in DRAIN on a cycle with s_valid=0, hold wr_en=0 and s_unload=0 and keep j (stall, no timeout).
REQ-016 SHALL enter FIN after the N-th write, pulse done=1 for 1 cycle there, and return to IDLE in the next cycle.
REQ-017 SHALL ignore start outside IDLE, including start asserted in the same cycle as done.
REQ-018 SHALL keep rd_en, wr_en, s_load, s_unload and s_rst low in every state and cycle not listed above.
REQ-019 SHALL make the fill-to-write latency for N words, when s_valid is already high, equal to 1 (CLR) + N + 2 + 1 (WAIT) cycles before the first wr_en.

Reset
REQ-020 SHALL, while rst=0, asynchronously force state IDLE and set busy, done, error, rd_en, wr_en, s_load and s_unload to 0, s_rst to 1, and all counters, addresses, s_din, rd_addr, wr_addr and wr_data to 0.
REQ-021 SHALL, on rst deasserting mid-operation, restart from IDLE with no residual strobes, and the first accepted start SHALL behave exactly as after power-up.

Verification (LOG_INPUT_NUM=2, N=4, ADDR_WIDTH=12)
REQ-022 SHALL cover basic sort: src[0x10..0x13]={9,3,7,1}, start with src_base=0x10, dst_base=0x20, sorter model ascending -> s_load words in order 9,3,7,1; writes 0x20..0x23={1,3,7,9}; one done pulse; error=0.
REQ-023 SHALL cover address wrap: src_base=0xFFE -> rd_addr sequence 0xFFE, 0xFFF, 0x000, 0x001.
REQ-024 SHALL cover drain stall: s_valid dropped for 3 cycles after the 2nd write -> exactly 4 writes, no wr_en during the stall, done after the 4th write.
REQ-025 SHALL cover timeout: TIMEOUT=20 with s_valid never asserted -> error=1 after 20 WAIT cycles, 1-cycle s_rst, return to IDLE, no done; the next start clears error.
REQ-026 SHALL cover busy rejection: start re-asserted in every FILL/DRAIN cycle -> single transfer only; captured bases unchanged.
REQ-027 SHALL cover mid-reset: rst=0 during FILL at the 2nd rd_en -> all strobes 0 immediately and s_rst=1; after release, a new start completes a correct 4-word sort.
